fir_output_conditioner: RTL
===========================

Name: fir_output_conditioner

Overview:
- Stage directly downstream of the pipelined FIR filter. Consumes the full-precision OUTP_WIDTH result stream `y` plus a qualifying valid.
- Operations, in order: optional decimation by DECIM, round-half-up requantisation by SHIFT bits, saturation to OUT_WIDTH, buffering in a small FIFO.
- Presents the result on a ready/valid interface to the DAC/capture logic.
- Reports saturation and overflow events.

Parameters:
- IN_WIDTH, 32, width of FIR output sample (two's complement).
- OUT_WIDTH, 16, width of conditioned output sample.
- SHIFT, 15, right-shift applied after rounding. Legal range 0..IN_WIDTH-OUT_WIDTH+? (0..IN_WIDTH-1).
- DECIM, 1, keep 1 of every DECIM valid input samples. Must be ≥1.
- DEPTH, 4, output FIFO entries. Must be a power of two, ≥2.

Ports:
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, in_data holds a new FIR sample this cycle.
- in_data, in, IN_WIDTH, signed FIR output y.
- out_valid, out, 1, out_data holds a valid conditioned sample.
- out_ready, in, 1, consumer accepts out_data this cycle.
- out_data, out, OUT_WIDTH, signed conditioned sample.
- clear_flags, in, 1, synchronous clear of overflow and sat_count.
- overflow, out, 1, sticky: a sample was dropped because the FIFO was full.
- sat_count, out, 16, number of saturated samples; holds at 0xFFFF.

Behaviour:
- Reset (async assert, sync-to-clk deassert assumed by the top level):
  - Decimation phase = 0.
  - Pipeline valids = 0.
  - FIFO empty.
  - out_valid=0, out_data=0, overflow=0, sat_count=0.
- Decimation:
  - Phase counter 0..DECIM-1 advances only on in_valid and wraps to 0.
  - A sample is kept when in_valid and phase==0, so the first sample after reset is kept.
  - DECIM=1 keeps every sample.
- Stage 1 (register): r1 = in_data + (SHIFT>0 ? 2^(SHIFT-1) : 0).
  - Computed in IN_WIDTH+1 bits, signed, so no wrap.
  - v1 = kept.
- Stage 2 (register): s = r1 >>> SHIFT (arithmetic).
  - If s > 2^(OUT_WIDTH-1)-1, result = 0x7FF…F and sat event.
  - If s < -2^(OUT_WIDTH-1), result = 0x800…0 and sat event.
  - Otherwise result = s[OUT_WIDTH-1:0].
  - v2 = v1.
- FIFO push when v2=1 at the clock edge.
- Latency: a kept sample at the in_valid cycle t is written to the FIFO at the end of cycle t+2. It appears at out_data with out_valid=1 in cycle t+3 if the FIFO was empty.
- FIFO is first-word-fall-through:
  - out_valid = !empty; out_data = head entry; out_data = 0 when empty.
  - Pop on out_valid & out_ready.
- Full FIFO:
  - Push with a pop in the same cycle: both occur, so the push is accepted.
  - Push without a pop: the sample is dropped, overflow←1, and FIFO contents are unchanged.
- Empty FIFO: out_ready is ignored, no pop occurs, and pointers do not move.
- Push and pop in the same cycle on a non-empty, non-full FIFO: occupancy is unchanged.
- sat_count increments on each stage-2 sat event, including samples later dropped. It saturates at 0xFFFF.
- clear_flags in the same cycle as a new event: the clear is applied first, then the event. Result: overflow=1 or sat_count=1 respectively.
- Reset mid-operation: all in-flight and buffered samples are discarded immediately. No partial output.
- No internal stall: in_valid may be high every cycle, because the FIR produces one sample per clock.

Decomposition:
- Package fir_pkg:
  - Default widths: IN_WIDTH, OUT_WIDTH.
  - Typedefs: fir_sample_t (signed IN_WIDTH) and out_sample_t (signed OUT_WIDTH).
  - A pure function sat_round(value, shift) used by RTL and testbench model.
- Sub-module fir_sync_fifo (DEPTH, WIDTH):
  - Pointers with an extra wrap bit.
  - full/empty outputs and push/pop inputs.
  - Push and pop in the same cycle when full is permitted.
  - Async active-low reset.

Test Plan:
- DECIM=1, SHIFT=15, out_ready=1; in_data 0x00004000, 0xFFFFBFFF, 0xFFFFC000 on consecutive cycles → out_data 0x0001, 0xFFFF, 0x0000 in cycles t+3..t+5; sat_count=0.
- Saturation: in_data 0x3FFFFFFF → 0x7FFF, and 0x80000000 → 0x8000, giving sat_count=2. Boundary in_data 0xC0000000 → 0x8000 with no sat (sat_count stays 2). Then clear_flags=1 in the same cycle as another sat event → sat_count=1.
- Decimation: DECIM=3, SHIFT=0, OUT_WIDTH=16, in_data 1..9 with in_valid gaps inserted → outputs exactly 1, 4, 7.
- Backpressure: DEPTH=4, out_ready=0, 6 kept samples A..F → FIFO holds A..D and overflow=1. Raise out_ready → A, B, C, D drained in order, then out_valid=0.
- Full push+pop: FIFO full with out_ready=1 and a new sample arriving the same cycle → no drop, overflow stays 0, occupancy stays 4.
- Reset mid-stream: assert rst_n=0 with 3 entries buffered and 2 in the pipeline → out_valid=0, out_data=0, and all flags clear immediately (asynchronously). After release, the first in_valid sample is kept and emerges at t+3.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths, sample types and the requantisation helper for the FIR output conditioner.
package fir_pkg;

    localparam int FIR_IN_WIDTH  = 32;
    localparam int FIR_OUT_WIDTH = 16;
    localparam int WIDE          = 64;

    typedef logic signed [FIR_IN_WIDTH-1:0]  fir_sample_t;
    typedef logic signed [FIR_OUT_WIDTH-1:0] out_sample_t;
    typedef logic signed [WIDE-1:0]          wide_t;

    typedef struct packed {
        logic  sat;
        wide_t data;
    } sat_res_t;

    // value already carries the rounding offset; shift then clamp to a signed out_w range
    function automatic sat_res_t sat_round(input wide_t value, input int shift, input int out_w);
        sat_res_t res;
        wide_t    s;
        wide_t    max_v;
        wide_t    min_v;
        s     = value >>> shift;
        max_v = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
        min_v = -(wide_t'(1) <<< (out_w - 1));
        res.sat  = 1'b1;
        res.data = s;
        if (s > max_v) begin
            res.data = max_v;
        end else if (s < min_v) begin
            res.data = min_v;
        end else begin
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through FIFO; extra pointer wrap bit distinguishes full from empty.
module fir_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // a pop on a full FIFO frees the slot the simultaneous push lands in
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/fir_output_conditioner.sv
// Decimates, rounds, saturates and buffers the FIR result stream for the DAC/capture side.
module fir_output_conditioner
    import fir_pkg::*;
#(
    parameter int IN_WIDTH  = FIR_IN_WIDTH,
    parameter int OUT_WIDTH = FIR_OUT_WIDTH,
    parameter int SHIFT     = 15,
    parameter int DECIM     = 1,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    input  logic                 clear_flags,
    output logic                 overflow,
    output logic [15:0]          sat_count
);

    localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [PW-1:0]     PHASE_LAST = PW'(DECIM - 1);
    localparam logic [IN_WIDTH:0] RND        = (SHIFT > 0) ? ((IN_WIDTH + 1)'(1) << RSH) : '0;

    logic [PW-1:0]        phase_q, phase_d;
    logic                 kept;
    logic                 v1_q;
    logic [IN_WIDTH:0]    r1_q, r1_d;
    logic                 v2_q;
    logic                 sat2_q;
    logic [OUT_WIDTH-1:0] d2_q;
    logic [OUT_WIDTH:0]   s2_d;
    logic                 ovf_q, ovf_d;
    logic [15:0]          satc_q, satc_d;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 drop;
    logic                 sat_event;

    function automatic logic [OUT_WIDTH:0] requant(input logic [IN_WIDTH:0] r);
        wide_t    v;
        sat_res_t res;
        v   = {{(WIDE - IN_WIDTH - 1){r[IN_WIDTH]}}, r};
        res = sat_round(v, SHIFT, OUT_WIDTH);
        return {res.sat, res.data[OUT_WIDTH-1:0]};
    endfunction

    assign kept = in_valid && (phase_q == '0);

    always_comb begin
        phase_d = phase_q;
        if (in_valid) begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
        end
    end

    // one extra bit keeps the rounding offset from wrapping the most positive sample
    assign r1_d = {in_data[IN_WIDTH-1], in_data} + RND;
    assign s2_d = requant(r1_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            v1_q    <= 1'b0;
            r1_q    <= '0;
            v2_q    <= 1'b0;
            sat2_q  <= 1'b0;
            d2_q    <= '0;
        end else begin
            phase_q <= phase_d;
            v1_q    <= kept;
            r1_q    <= r1_d;
            v2_q    <= v1_q;
            sat2_q  <= s2_d[OUT_WIDTH];
            d2_q    <= s2_d[OUT_WIDTH-1:0];
        end
    end

    fir_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (v2_q),
        .wdata (d2_q),
        .pop   (out_ready),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;

    // full implies non-empty, so only a missing ready can block the pop that would make room
    assign drop      = v2_q && fifo_full && !out_ready;
    assign sat_event = v2_q && sat2_q;

    always_comb begin
        ovf_d  = clear_flags ? 1'b0 : ovf_q;
        satc_d = clear_flags ? 16'h0000 : satc_q;
        if (drop) begin
            ovf_d = 1'b1;
        end
        if (sat_event && (satc_d != 16'hFFFF)) begin
            satc_d = satc_d + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            satc_q <= '0;
        end else begin
            ovf_q  <= ovf_d;
            satc_q <= satc_d;
        end
    end

    assign overflow  = ovf_q;
    assign sat_count = satc_q;

endmodule
